bcd_updown_counter_multi: RTL and testbench
===========================================

// Module: bcd_updown_counter_multi
// PURPOSE
//  Parametrised multi-digit up/down counter with per-digit radix (default BCD) and synchronous load.
//  Digits carry/borrow within one clock and a registered terminal-count flag marks wrap events.
//  Serves as the generic counting core for display/timer datapaths; generalises the single-digit mod-10 counter.
// PARAMETERS
//  DIGITS  2   number of cascaded digits (1..8)
//  RADIX   10  modulus of every digit (2..16); DW = $clog2(RADIX) bits per digit
// PORTS
//  clk         in   1          rising-edge clock
//  reset       in   1          asynchronous, active-high; clears all state
//  load        in   1          synchronous load of data_in
//  counter_on  in   1          count enable
//  count_up    in   1          1 = increment, 0 = decrement
//  data_in     in   DIGITS*DW  load value; digit i at [i*DW +: DW], digit 0 = LSD
//  count       out  DIGITS*DW  current value, same packing
//  tc          out  1          registered terminal-count / wrap flag
//  at_max      out  1          comb: every digit == RADIX-1
//  at_zero     out  1          comb: every digit == 0
// BEHAVIOUR
//  - Reset (async assert, sync-safe release): count = 0, tc = 0, independent of clk.
//  - Priority per edge: reset > load > counter_on > hold.
//  - load: each digit of data_in >= RADIX is clamped to RADIX-1 before storing; tc <= 0.
//  - counter_on & count_up: LSD +1; a digit at RADIX-1 wraps to 0 and carries into the next digit,
//    full ripple resolved in the same cycle (e.g. 099 -> 100 in one edge).
//  - counter_on & !count_up: LSD -1; a digit at 0 wraps to RADIX-1 and borrows from the next digit.
//  - Whole-counter wrap: up from all-max -> all-zero; down from all-zero -> all-max.
//  - tc: registered with count; = 1 for exactly the cycle following a whole-counter wrap edge
//    (visible together with the wrapped value); 0 otherwise, including hold and load cycles.
//  - Consecutive wraps (e.g. DIGITS=1, RADIX=2, continuous counting) keep tc high on each wrap cycle.
//  - count_up may change every cycle; direction is sampled on the same edge as counter_on.
//  - counter_on = 0 and load = 0: count and tc hold / clear respectively (tc <= 0).
//  - Reset asserted mid-ripple or mid-load: reset wins immediately; no partial update survives.
//  - No X propagation: every register has an explicit reset value; no initial-block reliance.
// CONFIGURATION
//  COUNTER_SAT_EN defined: saturating mode. Up at all-max holds all-max; down at all-zero holds
//    all-zero; tc = 1 in the cycle after each blocked count attempt (overflow/underflow indicator).
//  COUNTER_SAT_EN undefined: wrapping mode as described above; no saturation logic synthesised.
// TESTING  (DIGITS=2, RADIX=10, values shown as packed hex)
//  1. count=8'h37, reset pulsed between clk edges -> count=8'h00, tc=0 before next edge.
//  2. load 8'h98, then up x2 -> 8'h99 (tc=0), 8'h00 (tc=1); next up -> 8'h01, tc=0.
//  3. load 8'h10, then down x2 -> 8'h09, 8'h08; load 8'h00, down -> 8'h99 with tc=1.
//  4. load=1, counter_on=1, data_in=8'h5C -> count=8'h59 (clamp, load wins), tc=0.
//  5. counter_on=0 for 5 cycles at 8'h42 with count_up toggling -> count stays 8'h42, tc=0.
//  6. COUNTER_SAT_EN: at 8'h99, up x3 -> stays 8'h99, tc=1 each cycle; at 8'h00 down -> stays, tc=1.

Source files
------------

// File: rtl/bcd_updown_counter_multi_if.sv
// Bus bundle for bcd_updown_counter_multi.
//   master : drives load, counter_on, count_up and data_in; observes count, tc, at_max and at_zero
//   slave  : the counter core
// Digit i occupies [i*DW +: DW] of data_in and count, and digit 0 is the least significant digit.
interface bcd_updown_counter_multi_if #(
    parameter int unsigned DIGITS = 2,
    parameter int unsigned RADIX  = 10
);
    localparam int unsigned DW = $clog2(RADIX);
    localparam int unsigned CW = DIGITS * DW;

    logic          load;
    logic          counter_on;
    logic          count_up;
    logic [CW-1:0] data_in;
    logic [CW-1:0] count;
    logic          tc;
    logic          at_max;
    logic          at_zero;

    modport master (
        output load, counter_on, count_up, data_in,
        input  count, tc, at_max, at_zero
    );

    modport slave (
        input  load, counter_on, count_up, data_in,
        output count, tc, at_max, at_zero
    );
endinterface

// File: rtl/bcd_updown_counter_multi.sv
// Multi-digit up/down counter. Every digit has the same radix (default BCD).
// The counter has a synchronous load that clamps out-of-range digits to RADIX-1.
// A carry or borrow ripples through all digits within one clock.
// tc is a registered flag that marks a whole-counter wrap.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high; clears count and tc
//   bus   : slave modport of bcd_updown_counter_multi_if
//           (load, counter_on, count_up, data_in -> count, tc, at_max, at_zero)
// Configuration macro:
//   COUNTER_SAT_EN : when defined, the counter saturates at all-max and at all-zero instead of
//                    wrapping, and tc flags each count attempt that was blocked.
module bcd_updown_counter_multi #(
    parameter int unsigned DIGITS = 2,
    parameter int unsigned RADIX  = 10
) (
    input  logic                             clk,
    input  logic                             reset,
    bcd_updown_counter_multi_if.slave        bus
);
    localparam int unsigned   DW   = $clog2(RADIX);
    localparam int unsigned   CW   = DIGITS * DW;
    localparam logic [DW-1:0] DMAX = DW'(RADIX - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          tc_q;
    logic          tc_d;
    logic [CW-1:0] load_val;
    logic [CW-1:0] step_val;
    logic          wrap;
    logic          all_max;
    logic          all_zero;
    logic [DW-1:0] ld_digit;
    logic [DW-1:0] cnt_digit;

    // Clamp each incoming digit to the legal range [0, RADIX-1].
    always_comb begin
        load_val = '0;
        ld_digit = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            ld_digit = bus.data_in[i*DW +: DW];
            load_val[i*DW +: DW] = ({1'b0, ld_digit} >= (DW+1)'(RADIX)) ? DMAX : ld_digit;
        end
    end

    // Single-cycle ripple. wrap stays set only if every digit wrapped.
    always_comb begin
        step_val  = count_q;
        wrap      = 1'b1;
        cnt_digit = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (wrap) begin
                cnt_digit = count_q[i*DW +: DW];
                if (bus.count_up) begin
                    if (cnt_digit == DMAX) begin
                        step_val[i*DW +: DW] = '0;
                    end else begin
                        step_val[i*DW +: DW] = cnt_digit + DW'(1);
                        wrap = 1'b0;
                    end
                end else begin
                    if (cnt_digit == '0) begin
                        step_val[i*DW +: DW] = DMAX;
                    end else begin
                        step_val[i*DW +: DW] = cnt_digit - DW'(1);
                        wrap = 1'b0;
                    end
                end
            end
        end
    end

    // Priority: load > count > hold. tc is high only after a wrap, or after a blocked count in saturating mode.
    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        if (bus.load) begin
            count_d = load_val;
        end else if (bus.counter_on) begin
            tc_d = wrap;
`ifdef COUNTER_SAT_EN
            if (!wrap) begin
                count_d = step_val;
            end
`else
            count_d = step_val;
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

    // Combinational all-max and all-zero detection on the stored value.
    always_comb begin
        all_max  = 1'b1;
        all_zero = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (count_q[i*DW +: DW] != DMAX) all_max  = 1'b0;
            if (count_q[i*DW +: DW] != '0)   all_zero = 1'b0;
        end
    end

    assign bus.count   = count_q;
    assign bus.tc      = tc_q;
    assign bus.at_max  = all_max;
    assign bus.at_zero = all_zero;

endmodule

// File: tb/tb_bcd_updown_counter_multi.sv
// Testbench for bcd_updown_counter_multi with DIGITS=2 and RADIX=10.
// It applies a table of directed vectors, then hand-written reset sequences, then random cycles
// checked against a decimal integer model. Expected values pass through a scoreboard queue.
module tb_bcd_updown_counter_multi;
    logic clk = 1'b0;
    logic reset;

    bcd_updown_counter_multi_if #(.DIGITS(2), .RADIX(10)) bus ();

    bcd_updown_counter_multi #(.DIGITS(2), .RADIX(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       ld;
        logic       on;
        logic       up;
        logic [7:0] din;
        logic [7:0] ec;
        logic       etc;
    } vec_t;

    typedef struct {
        logic [7:0] ec;
        logic       etc;
        string      name;
    } exp_t;

    vec_t tbl[$];
    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   mv    = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs(input string name, input logic [7:0] ec, input logic etc);
        check({name, ".count"},   bus.count, ec);
        check({name, ".tc"},      8'(bus.tc), 8'(etc));
        check({name, ".at_max"},  8'(bus.at_max), 8'(ec == 8'h99));
        check({name, ".at_zero"}, 8'(bus.at_zero), 8'(ec == 8'h00));
    endtask

    // Drive one cycle and push its expected result. The result is popped and compared after the edge.
    task automatic apply(input logic ld, input logic on, input logic up, input logic [7:0] din,
                         input logic [7:0] ec, input logic etc, input string name);
        exp_t e;
        @(negedge clk);
        bus.load       = ld;
        bus.counter_on = on;
        bus.count_up   = up;
        bus.data_in    = din;
        sb_q.push_back('{ec: ec, etc: etc, name: name});
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL scoreboard_empty: got 0 entries expected 1");
        end else begin
            e = sb_q.pop_front();
            check_outputs(e.name, e.ec, e.etc);
        end
    endtask

    function automatic logic [7:0] clamp(input logic [7:0] h);
        logic [3:0] hi;
        logic [3:0] lo;
        hi = (h[7:4] > 4'd9) ? 4'd9 : h[7:4];
        lo = (h[3:0] > 4'd9) ? 4'd9 : h[3:0];
        return {hi, lo};
    endfunction

    function automatic int h2i(input logic [7:0] h);
        return int'(h[7:4]) * 10 + int'(h[3:0]);
    endfunction

    function automatic logic [7:0] i2h(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    // Decimal reference model: it updates mv and returns the expected tc.
    function automatic logic model(input logic ld, input logic on, input logic up, input logic [7:0] din);
        logic t;
        t = 1'b0;
        if (ld) begin
            mv = h2i(clamp(din));
        end else if (on) begin
            if (up) begin
                if (mv == 99) begin
                    t = 1'b1;
`ifndef COUNTER_SAT_EN
                    mv = 0;
`endif
                end else begin
                    mv = mv + 1;
                end
            end else begin
                if (mv == 0) begin
                    t = 1'b1;
`ifndef COUNTER_SAT_EN
                    mv = 99;
`endif
                end else begin
                    mv = mv - 1;
                end
            end
        end
        return t;
    endfunction

    function automatic vec_t mk(input logic ld, input logic on, input logic up, input logic [7:0] din,
                                input logic [7:0] ec, input logic etc);
        vec_t v;
        v.ld = ld; v.on = on; v.up = up; v.din = din; v.ec = ec; v.etc = etc;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] din;
        logic       ld;
        logic       on;
        logic       up;
        logic       et;

        reset          = 1'b1;
        bus.load       = 1'b0;
        bus.counter_on = 1'b0;
        bus.count_up   = 1'b0;
        bus.data_in    = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset_state", 8'h00, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // Directed table
        tbl.push_back(mk(1, 0, 0, 8'h98, 8'h98, 0));
        tbl.push_back(mk(0, 1, 1, 8'h00, 8'h99, 0));
`ifdef COUNTER_SAT_EN
        tbl.push_back(mk(0, 1, 1, 8'h00, 8'h99, 1));
        tbl.push_back(mk(0, 1, 1, 8'h00, 8'h99, 1));
        tbl.push_back(mk(0, 1, 1, 8'h00, 8'h99, 1));
`else
        tbl.push_back(mk(0, 1, 1, 8'h00, 8'h00, 1));
        tbl.push_back(mk(0, 1, 1, 8'h00, 8'h01, 0));
        tbl.push_back(mk(0, 1, 1, 8'h00, 8'h02, 0));
`endif
        tbl.push_back(mk(1, 0, 0, 8'h10, 8'h10, 0));
        tbl.push_back(mk(0, 1, 0, 8'h00, 8'h09, 0));
        tbl.push_back(mk(0, 1, 0, 8'h00, 8'h08, 0));
        tbl.push_back(mk(1, 0, 1, 8'h00, 8'h00, 0));
`ifdef COUNTER_SAT_EN
        tbl.push_back(mk(0, 1, 0, 8'h00, 8'h00, 1));
`else
        tbl.push_back(mk(0, 1, 0, 8'h00, 8'h99, 1));
`endif
        tbl.push_back(mk(1, 1, 1, 8'h5C, 8'h59, 0));
        tbl.push_back(mk(1, 0, 0, 8'h42, 8'h42, 0));
        for (int i = 0; i < 5; i++) begin
            tbl.push_back(mk(0, 0, 1'(i % 2), 8'hA5, 8'h42, 0));
        end
        tbl.push_back(mk(1, 0, 0, 8'hFF, 8'h99, 0));
        tbl.push_back(mk(0, 1, 0, 8'h00, 8'h98, 0));
        tbl.push_back(mk(1, 0, 0, 8'h3E, 8'h39, 0));
        tbl.push_back(mk(0, 1, 1, 8'h00, 8'h40, 0));
        tbl.push_back(mk(0, 1, 0, 8'h00, 8'h39, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].ld, tbl[i].on, tbl[i].up, tbl[i].din, tbl[i].ec, tbl[i].etc,
                  $sformatf("tbl%0d", i));
        end

        // Asynchronous reset that lands between clock edges
        apply(1, 0, 0, 8'h37, 8'h37, 0, "pre_async_load");
        @(negedge clk);
        bus.load = 1'b0;
        bus.counter_on = 1'b0;
        #2 reset = 1'b1;
        #1 check_outputs("async_reset_count", 8'h00, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // tc set by a wrap (or by a blocked count) must clear on an asynchronous reset
        apply(1, 0, 0, 8'h99, 8'h99, 0, "pre_tc_load");
`ifdef COUNTER_SAT_EN
        apply(0, 1, 1, 8'h00, 8'h99, 1, "tc_set");
`else
        apply(0, 1, 1, 8'h00, 8'h00, 1, "tc_set");
`endif
        #2 reset = 1'b1;
        #1 check_outputs("async_reset_tc", 8'h00, 1'b0);

        // Reset held across an edge where load is also asserted: reset wins
        @(negedge clk);
        bus.load    = 1'b1;
        bus.data_in = 8'h55;
        @(posedge clk);
        #1 check_outputs("reset_over_load", 8'h00, 1'b0);
        @(negedge clk);
        reset    = 1'b0;
        bus.load = 1'b0;

        // Random cycles checked against the decimal model
        mv = 0;
        et = model(1'b1, 1'b0, 1'b0, 8'h95);
        apply(1, 0, 0, 8'h95, i2h(mv), et, "rnd_seed");
        for (int i = 0; i < 300; i++) begin
            ld  = ($urandom_range(0, 15) == 0);
            on  = ($urandom_range(0, 7) != 0);
            up  = ($urandom_range(0, 2) != 0) ? (i < 150) : (i >= 150);
            din = 8'($urandom);
            et  = model(ld, on, up, din);
            apply(ld, on, up, din, i2h(mv), et, $sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
